// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout, widths and sink FSM states
package noc_pkg;

    localparam int FLIT_W = 11;
    localparam int DATA_W = 8;
    localparam int IP_W   = 4;

    typedef struct packed {
        logic [2:0] route;
        logic [3:0] payload;
        logic [3:0] dest;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK_HI = 2'd1,
        ACK_LO = 2'd2
    } sink_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - single-clock FIFO, head word shown combinationally on pop_data
module noc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Storage is cleared on reset so the head reads zero out of reset.
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_flit_sink.sv
// rtl/noc_flit_sink.sv - 4-phase bundled-data receiver that filters flits by dest IP
module noc_flit_sink
    import noc_pkg::*;
#(
    parameter logic [3:0] MY_IP       = 4'b0010,
    parameter int         FLIT_W      = noc_pkg::FLIT_W,
    parameter int         DATA_W      = noc_pkg::DATA_W,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    input  logic [FLIT_W-1:0] in_data,
    output logic              in_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [15:0]       rx_cnt,
    output logic [7:0]        drop_cnt,
    output logic              err_drop
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    sink_state_e            state;
    sink_state_e            state_next;
    logic                   accept;
    logic                   dest_match;
    logic                   push;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    flit_t                  flit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // in_data is only looked at once req_s confirms the bundle has settled.
    assign flit       = in_data;
    assign dest_match = (flit.dest == MY_IP);
    assign push       = accept && dest_match;
    assign drop       = accept && !dest_match;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !fifo_full) begin
                    state_next = ACK_HI;
                    accept     = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_next = ACK_LO;
                end
            end
            ACK_LO: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ack   <= 1'b0;
            err_drop <= 1'b0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            in_ack   <= (state_next == ACK_HI);
            err_drop <= drop;
            if (push) begin
                rx_cnt <= rx_cnt + 16'd1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    noc_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data[DATA_W-1:0]),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_noc_flit_sink.sv
// tb/tb_noc_flit_sink.sv - scoreboard bench for noc_flit_sink
module tb_noc_flit_sink;

    localparam int         SYNC  = 3;
    localparam logic [3:0] MY_IP = 4'h2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_req;
    logic [10:0] in_data;
    logic        in_ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] rx_cnt;
    logic [7:0]  drop_cnt;
    logic        err_drop;

    int errors = 0;
    int checks = 0;
    int drop_pulses = 0;
    int popped = 0;
    logic [7:0] sb [$];

    noc_flit_sink #(
        .MY_IP       (MY_IP),
        .FLIT_W      (11),
        .DATA_W      (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rx_cnt    (rx_cnt),
        .drop_cnt  (drop_cnt),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A pop happens at the next posedge when valid & ready are seen here.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_drop) drop_pulses++;
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("out_data", 32'(out_data), 32'(sb.pop_front()));
                    popped++;
                end
            end
        end
    end

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (in_ack !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(in_ack), 32'(lvl));
    endtask

    task automatic send_flit(input logic [10:0] f, input int max_gap);
        #($urandom_range(0, max_gap));
        in_data = f;
        #1;
        in_req = 1'b1;
        if (f[3:0] == MY_IP) sb.push_back(f[7:0]);
        wait_ack(1'b1, "ack_rise");
        #($urandom_range(0, max_gap));
        in_req = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        set_ready(1'b1);
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(sb.size()), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_req = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_drop;
        int base_pop;
        int exp_rx;
        bit done;

        rst = 1'b1; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ack", 32'(in_ack), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_rx_cnt", 32'(rx_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_err_drop", 32'(err_drop), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single accepted flit, ack latency counted in clock edges
        set_ready(1'b1);
        in_data = 11'h0F2;
        in_req  = 1'b1;
        sb.push_back(8'hF2);
        n = 0;
        while (!in_ack && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_ack_latency", 32'(n), 32'(SYNC + 1));
        check("t1_valid_with_ack", 32'(out_valid), 1);
        check("t1_data_with_ack", 32'(out_data), 32'h0F2);
        in_req = 1'b0;
        wait_ack(1'b0, "t1_ack_fall");
        repeat (3) @(negedge clk);
        check("t1_rx_cnt", 32'(rx_cnt), 1);
        check("t1_drop_cnt", 32'(drop_cnt), 0);
        check("t1_popped", 32'(popped), 1);

        // 2: misrouted flit is acked and dropped
        base_drop = drop_pulses;
        send_flit(11'h0AE, 0);
        repeat (3) @(negedge clk);
        check("t2_drop_cnt", 32'(drop_cnt), 1);
        check("t2_rx_cnt", 32'(rx_cnt), 1);
        check("t2_pulses", 32'(drop_pulses - base_drop), 1);
        check("t2_no_valid", 32'(out_valid), 0);

        // 3: fill FIFO, fifth flit is held until one pop
        set_ready(1'b0);
        send_flit(11'h0A2, 2);
        send_flit(11'h0B2, 2);
        send_flit(11'h0C2, 2);
        send_flit(11'h0D2, 2);
        in_data = 11'h0E2;
        #1;
        in_req = 1'b1;
        sb.push_back(8'hE2);
        repeat (12) @(negedge clk);
        check("t3_backpressure", 32'(in_ack), 0);
        check("t3_full_valid", 32'(out_valid), 1);
        check("t3_head", 32'(out_data), 32'hA2);
        set_ready(1'b1);
        set_ready(1'b0);
        wait_ack(1'b1, "t3_ack_after_pop");
        in_req = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        drain("t3_drain");
        check("t3_rx_cnt", 32'(rx_cnt), 6);

        // 4: reset while in ACK_HI with two buffered flits
        set_ready(1'b0);
        send_flit(11'h032, 1);
        send_flit(11'h042, 1);
        in_data = 11'h052;
        #1;
        in_req = 1'b1;
        wait_ack(1'b1, "t4_ack_hi");
        #2;
        rst = 1'b1;
        #1;
        check("t4_ack_async", 32'(in_ack), 0);
        check("t4_valid_async", 32'(out_valid), 0);
        check("t4_rx_cnt", 32'(rx_cnt), 0);
        check("t4_drop_cnt", 32'(drop_cnt), 0);
        sb.delete();
        in_req = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        base_pop = popped;
        send_flit(11'h012, 2);
        drain("t4_drain");
        check("t4_rx_after", 32'(rx_cnt), 1);
        check("t4_popped", 32'(popped - base_pop), 1);

        // 5: 300 misrouted flits saturate drop_cnt
        do_reset();
        base_drop = drop_pulses;
        for (int i = 0; i < 300; i++) begin
            send_flit({3'($urandom), 4'($urandom), 4'h7}, 3);
        end
        repeat (3) @(negedge clk);
        check("t5_drop_sat", 32'(drop_cnt), 255);
        check("t5_rx_cnt", 32'(rx_cnt), 0);
        check("t5_pulses", 32'(drop_pulses - base_drop), 300);
        check("t5_no_valid", 32'(out_valid), 0);

        // 6: random mixed traffic against random consumer
        do_reset();
        base_drop = drop_pulses;
        exp_rx = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [3:0] d;
                    d = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) d = MY_IP;
                    else if (d == MY_IP) d = 4'h3;
                    if (d == MY_IP) exp_rx++;
                    send_flit({3'($urandom), 4'($urandom), d}, 25);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("t6_drain");
        repeat (2) @(negedge clk);
        check("t6_rx_cnt", 32'(rx_cnt), 32'(exp_rx));
        check("t6_pulses", 32'(drop_pulses - base_drop), 32'(1000 - exp_rx));
        check("t6_drop_cnt", 32'(drop_cnt), 32'(((1000 - exp_rx) > 255) ? 255 : (1000 - exp_rx)));
        check("t6_total", 32'(int'(rx_cnt) + drop_pulses - base_drop), 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
